// File: rtl/ram_mp_pkg.sv
// Shared types and helpers for the multi-port clearable RAM.
// be_merge is used by both the array write and the read bypass.
package ram_mp_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } state_t;

    // Widest word the helpers accept; callers cast in and out.
    localparam int MAX_DW = 1024;
    localparam int MAX_BE = MAX_DW / 8;

    function automatic logic [MAX_DW-1:0] be_merge(
        input logic [MAX_DW-1:0] old_word,
        input logic [MAX_DW-1:0] new_word,
        input logic [MAX_BE-1:0] be
    );
        logic [MAX_DW-1:0] r;
        r = old_word;
        for (int b = 0; b < MAX_BE; b++) begin
            if (be[b]) r[8*b +: 8] = new_word[8*b +: 8];
        end
        return r;
    endfunction

    function automatic logic in_range(
        input logic [31:0] addr,
        input int          depth
    );
        return addr < $unsigned(depth);
    endfunction

endpackage

// File: rtl/ram_clear_seq.sv
// Clear sequencer: sweeps the array to zero one word per cycle
// after reset or an accepted clear request, then reports ready.
module ram_clear_seq
    import ram_mp_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 13,
    parameter int DEPTH         = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr_req,
    output logic                     clr_we,
    output logic [ADDRESS_WIDTH-1:0] clr_addr,
    output logic                     ready
);

    localparam logic [ADDRESS_WIDTH-1:0] LAST = ADDRESS_WIDTH'(DEPTH - 1);

    state_t                   state;
    state_t                   state_nx;
    logic [ADDRESS_WIDTH-1:0] addr_nx;

    // State and sweep pointer registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= CLEAR;
            clr_addr <= '0;
        end else begin
            state    <= state_nx;
            clr_addr <= addr_nx;
        end
    end

    // Sweep one word per cycle; leave on the last entry.
    always_comb begin
        state_nx = state;
        addr_nx  = clr_addr;
        clr_we   = 1'b0;
        unique case (state)
            CLEAR: begin
                clr_we  = 1'b1;
                addr_nx = clr_addr + 1'b1;
                if (clr_addr == LAST) begin
                    state_nx = IDLE;
                    addr_nx  = '0;
                end
            end
            IDLE: begin
                if (clr_req) begin
                    state_nx = CLEAR;
                    addr_nx  = '0;
                end
            end
        endcase
    end

    assign ready = (state == IDLE);

endmodule

// File: rtl/ram_mp_clr.sv
// Multi-read-port RAM with byte-enable write, write-first bypass
// and a sequential zeroing sweep on reset or clear request.
module ram_mp_clr
    import ram_mp_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 13,
    parameter int DATA_WIDTH    = 64,
    parameter int DEPTH         = 16,
    parameter int NUM_RD        = 2
) (
    input  logic                            CLK,
    input  logic                            RST_N,
    input  logic                            CLR,
    input  logic                            WR_Enable,
    input  logic [DATA_WIDTH/8-1:0]         WR_BE,
    input  logic [ADDRESS_WIDTH-1:0]        address_WR,
    input  logic [DATA_WIDTH-1:0]           dataIn,
    input  logic [NUM_RD*ADDRESS_WIDTH-1:0] address_RD,
    output logic [NUM_RD*DATA_WIDTH-1:0]    dataOut,
    output logic                            READY,
    output logic                            WR_Drop
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_WIDTH-1:0]    mem [DEPTH];
    logic                     clr_we;
    logic [ADDRESS_WIDTH-1:0] clr_addr;
    logic                     ready;
    logic                     wr_go;
    logic                     drop;
    logic [IW-1:0]            wr_idx;
    logic [IW-1:0]            clr_idx;
    logic [DATA_WIDTH-1:0]    wr_word;
    logic                     unused_clr;

    ram_clear_seq #(
        .ADDRESS_WIDTH(ADDRESS_WIDTH),
        .DEPTH        (DEPTH)
    ) u_clr (
        .clk     (CLK),
        .rst_n   (RST_N),
        .clr_req (CLR),
        .clr_we  (clr_we),
        .clr_addr(clr_addr),
        .ready   (ready)
    );

    assign wr_idx     = address_WR[IW-1:0];
    assign clr_idx    = clr_addr[IW-1:0];
    assign unused_clr = ^clr_addr;

    // A user write lands only in IDLE, without a clear, in range.
    assign wr_go = ready & WR_Enable & ~CLR
                 & in_range(32'(address_WR), DEPTH);
    assign drop  = WR_Enable & ~wr_go
                 & (~ready | CLR | ~in_range(32'(address_WR), DEPTH));

    assign wr_word = DATA_WIDTH'(be_merge(
        MAX_DW'(mem[wr_idx]),
        MAX_DW'(dataIn),
        MAX_BE'(WR_BE)
    ));

    // Array write: sweep zeroes or user write; never during reset.
    always_ff @(posedge CLK) begin
        if (RST_N) begin
            if (clr_we) begin
                mem[clr_idx] <= '0;
            end else if (wr_go) begin
                mem[wr_idx] <= wr_word;
            end
        end
    end

    // Registered one-cycle pulse for each discarded write strobe.
    always_ff @(posedge CLK) begin
        if (!RST_N) WR_Drop <= 1'b0;
        else        WR_Drop <= drop;
    end

    assign READY = ready;

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDRESS_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0]    word;
        logic [DATA_WIDTH-1:0]    q;

        assign addr = address_RD[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];

        // Write-first bypass, zero for out-of-range addresses.
        always_comb begin
            word = '0;
            if (in_range(32'(addr), DEPTH)) begin
                if (wr_go && addr == address_WR) word = wr_word;
                else                             word = mem[addr[IW-1:0]];
            end
        end

        // Read register; forced to zero while clearing.
        always_ff @(posedge CLK) begin
            if (!RST_N || !ready || CLR) q <= '0;
            else                         q <= word;
        end

        assign dataOut[i*DATA_WIDTH +: DATA_WIDTH] = q;
    end

endmodule

// File: tb/tb_ram_mp_clr.sv
// Bench for ram_mp_clr: table vectors, corner sequences and random
// traffic, all checked against a countdown/array reference model.
module tb_ram_mp_clr;

    localparam int AW = 13;
    localparam int DW = 64;
    localparam int DP = 16;
    localparam int NR = 2;

    logic             CLK = 1'b0;
    logic             RST_N = 1'b0;
    logic             CLR = 1'b0;
    logic             WR_Enable = 1'b0;
    logic [DW/8-1:0]  WR_BE = '0;
    logic [AW-1:0]    address_WR = '0;
    logic [DW-1:0]    dataIn = '0;
    logic [NR*AW-1:0] address_RD = '0;
    logic [NR*DW-1:0] dataOut;
    logic             READY;
    logic             WR_Drop;

    int checks = 0;
    int errors = 0;

    ram_mp_clr #(
        .ADDRESS_WIDTH(AW),
        .DATA_WIDTH   (DW),
        .DEPTH        (DP),
        .NUM_RD       (NR)
    ) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .CLR       (CLR),
        .WR_Enable (WR_Enable),
        .WR_BE     (WR_BE),
        .address_WR(address_WR),
        .dataIn    (dataIn),
        .address_RD(address_RD),
        .dataOut   (dataOut),
        .READY     (READY),
        .WR_Drop   (WR_Drop)
    );

    always #5 CLK = ~CLK;

    // Reference model: array contents plus edges left until usable.
    bit [63:0] mm [DP];
    int        busy = 0;
    bit [63:0] e_d [NR];
    bit        e_rdy;
    bit        e_drop;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic void model_step();
        bit        hit;
        bit [63:0] nw;
        int        ra;
        if (!RST_N) begin
            busy = DP;
            foreach (mm[k]) mm[k] = 64'd0;
            foreach (e_d[p]) e_d[p] = 64'd0;
            e_rdy  = 1'b0;
            e_drop = 1'b0;
            return;
        end
        if (busy > 0) begin
            e_drop = WR_Enable;
            foreach (e_d[p]) e_d[p] = 64'd0;
            busy--;
        end else if (CLR) begin
            e_drop = WR_Enable;
            foreach (e_d[p]) e_d[p] = 64'd0;
            busy = DP;
            foreach (mm[k]) mm[k] = 64'd0;
        end else begin
            hit    = WR_Enable && (int'(address_WR) < DP);
            e_drop = WR_Enable && !hit;
            nw     = 64'd0;
            if (hit) begin
                nw = mm[address_WR[3:0]];
                for (int b = 0; b < 8; b++)
                    if (WR_BE[b]) nw[8*b +: 8] = dataIn[8*b +: 8];
            end
            for (int p = 0; p < NR; p++) begin
                ra = int'(address_RD[p*AW +: AW]);
                if (ra >= DP)                       e_d[p] = 64'd0;
                else if (hit && ra == int'(address_WR)) e_d[p] = nw;
                else                                e_d[p] = mm[ra];
            end
            if (hit) mm[address_WR[3:0]] = nw;
        end
        e_rdy = (busy == 0);
    endfunction

    task automatic apply(input logic rst, input logic clr, input logic we,
                         input logic [7:0] be, input logic [AW-1:0] wa,
                         input logic [63:0] din, input logic [AW-1:0] ra0,
                         input logic [AW-1:0] ra1);
        RST_N      = rst;
        CLR        = clr;
        WR_Enable  = we;
        WR_BE      = be;
        address_WR = wa;
        dataIn     = din;
        address_RD = {ra1, ra0};
        @(posedge CLK);
        model_step();
        #1;
        check("ready", 64'(READY), 64'(e_rdy));
        check("wr_drop", 64'(WR_Drop), 64'(e_drop));
        check("dout0", dataOut[63:0], e_d[0]);
        check("dout1", dataOut[127:64], e_d[1]);
    endtask

    task automatic idle(input logic [AW-1:0] ra0, input logic [AW-1:0] ra1);
        apply(1'b1, 1'b0, 1'b0, 8'h00, '0, 64'd0, ra0, ra1);
    endtask

    typedef struct {
        logic          clr;
        logic          we;
        logic [7:0]    be;
        logic [AW-1:0] wa;
        logic [63:0]   din;
        logic [AW-1:0] ra0;
        logic [AW-1:0] ra1;
        logic          x_rdy;
        logic          x_drop;
        logic [63:0]   x_d0;
        logic [63:0]   x_d1;
    } vec_t;

    vec_t tbl [12];

    initial begin
        //           clr we  be     wa  din                     ra0 ra1 rdy drp d0                      d1
        tbl[0]  = '{0, 1, 8'hFF, 5,  64'h1122334455667788, 5,  5,  1, 0, 64'h1122334455667788, 64'h1122334455667788};
        tbl[1]  = '{0, 1, 8'h0F, 5,  64'hAAAAAAAAAAAAAAAA, 5,  4,  1, 0, 64'h11223344AAAAAAAA, 64'h0};
        tbl[2]  = '{0, 0, 8'h00, 0,  64'h0,                5,  5,  1, 0, 64'h11223344AAAAAAAA, 64'h11223344AAAAAAAA};
        tbl[3]  = '{0, 1, 8'hFF, 4,  64'h4444,             0,  1,  1, 0, 64'h0,                64'h0};
        tbl[4]  = '{0, 1, 8'hFF, 3,  64'hDEAD,             3,  3,  1, 0, 64'hDEAD,             64'hDEAD};
        tbl[5]  = '{0, 1, 8'hFF, 3,  64'hBEEF,             3,  4,  1, 0, 64'hBEEF,             64'h4444};
        tbl[6]  = '{0, 1, 8'hFF, 20, 64'hFFFF,             20, 5,  1, 1, 64'h0,                64'h11223344AAAAAAAA};
        tbl[7]  = '{0, 0, 8'h00, 0,  64'h0,                3,  20, 1, 0, 64'hBEEF,             64'h0};
        tbl[8]  = '{0, 1, 8'h00, 6,  64'hFFFF,             6,  6,  1, 0, 64'h0,                64'h0};
        tbl[9]  = '{0, 1, 8'hFF, 7,  64'h55,               7,  6,  1, 0, 64'h55,               64'h0};
        tbl[10] = '{1, 1, 8'hFF, 7,  64'h99,               7,  7,  0, 1, 64'h0,                64'h0};
        tbl[11] = '{0, 1, 8'hFF, 2,  64'h1,                2,  2,  0, 1, 64'h0,                64'h0};

        // Reset for three cycles, then count edges until READY.
        for (int k = 0; k < 3; k++)
            apply(1'b0, 1'b0, 1'b0, 8'h00, '0, 64'd0, '0, '0);
        for (int k = 1; k <= DP; k++) begin
            idle('0, '0);
            check("ready_release", 64'(READY), 64'(k == DP));
        end
        for (int a = 0; a < DP; a += 2) begin
            idle(AW'(a), AW'(a + 1));
            check("zero_after_reset", dataOut, 128'd0);
        end

        // Table: byte enables, bypass, out of range, clear collision.
        for (int i = 0; i < 12; i++) begin
            apply(1'b1, tbl[i].clr, tbl[i].we, tbl[i].be, tbl[i].wa,
                  tbl[i].din, tbl[i].ra0, tbl[i].ra1);
            check($sformatf("vec%0d_ready", i), 64'(READY), 64'(tbl[i].x_rdy));
            check($sformatf("vec%0d_drop", i), 64'(WR_Drop), 64'(tbl[i].x_drop));
            check($sformatf("vec%0d_d0", i), dataOut[63:0], tbl[i].x_d0);
            check($sformatf("vec%0d_d1", i), dataOut[127:64], tbl[i].x_d1);
        end

        // Remainder of the clear started by vector 10.
        for (int k = 2; k <= DP; k++) begin
            idle(7, 5);
            check("ready_clear", 64'(READY), 64'(k == DP));
        end
        idle(7, 5);
        check("cleared_7_5", dataOut, 128'd0);

        // Reset during the sweep restarts it.
        apply(1'b1, 1'b0, 1'b1, 8'hFF, 15, 64'h1515, 15, 15);
        apply(1'b1, 1'b1, 1'b0, 8'h00, '0, 64'd0, '0, '0);
        for (int k = 1; k < 8; k++) idle('0, '0);
        apply(1'b0, 1'b0, 1'b1, 8'hFF, 1, 64'h77, '0, '0);
        apply(1'b0, 1'b0, 1'b0, 8'h00, '0, 64'd0, '0, '0);
        for (int k = 1; k <= DP; k++) begin
            idle(15, 1);
            check("ready_restart", 64'(READY), 64'(k == DP));
        end
        idle(15, 1);
        check("restart_zero", dataOut, 128'd0);

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            apply($urandom_range(63) != 0,
                  $urandom_range(40) == 0,
                  1'($urandom_range(1)),
                  8'($urandom),
                  AW'($urandom_range(19)),
                  {$urandom, $urandom},
                  AW'($urandom_range(19)),
                  AW'($urandom_range(19)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
